// File: rtl/pulse_stretch_pkg.sv
// Shared state encoding and default timing for the LED pulse stretcher.
// Pure type/constant package: no logic, no latency, no flow control.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam int DEF_CNT_W      = 21;
    localparam int DEF_ON_CYCLES  = 2000000;
    localparam int DEF_OFF_CYCLES = 1000000;
    localparam int DEF_PEND_W     = 4;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
// One-cycle update latency; zero is a combinational view of the count.
module load_down_counter #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches tick strobes into ON_CYCLES-long LED pulses separated by OFF_CYCLES gaps; outputs one cycle after tick.
// Ticks during a pulse queue in a saturating counter; PULSE_STRETCH_RETRIG_EN instead retriggers the current pulse.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int PEND_W     = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop_tick
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_e            state_q, state_d;
    logic              led_out_q, led_out_d;
    logic              busy_q, busy_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              drop_tick_q, drop_tick_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;
    // Transitions only need the zero flag; the raw count is left for debug.
    logic [CNT_W-1:0]  cnt_unused;

    load_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .cnt      (cnt_unused),
        .zero     (cnt_zero)
    );

`ifndef PULSE_STRETCH_RETRIG_EN
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W:0]   PEND_ONE = (PEND_W + 1)'(1);

    // Widened so a tick on top of a full queue can still be consumed at gap end.
    logic [PEND_W:0] pend_inc;
    logic [PEND_W:0] pend_dec;
    assign pend_inc = {1'b0, pending_q} + {{PEND_W{1'b0}}, tick_in};
    assign pend_dec = pend_inc - PEND_ONE;
`endif

    always_comb begin
        state_d      = state_q;
        drop_tick_d  = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = ON_LOAD;
        cnt_en       = 1'b0;
`ifdef PULSE_STRETCH_RETRIG_EN
        pending_d    = '0;
`else
        pending_d    = pending_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tick_in) begin
                    state_d  = ST_ON;
                    cnt_load = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_zero) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
`ifdef PULSE_STRETCH_RETRIG_EN
                if (tick_in) begin
                    state_d      = ST_ON;
                    cnt_load     = 1'b1;
                    cnt_load_val = ON_LOAD;
                end
`else
                if (tick_in) begin
                    if (pending_q == PEND_MAX) begin
                        drop_tick_d = 1'b1;
                    end else begin
                        pending_d = pending_q + PEND_W'(1);
                    end
                end
`endif
            end
            ST_GAP: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                if (tick_in) begin
                    state_d  = ST_ON;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
`else
                if (cnt_zero) begin
                    if (pend_inc != '0) begin
                        state_d   = ST_ON;
                        cnt_load  = 1'b1;
                        pending_d = pend_dec[PEND_W-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (tick_in) begin
                        if (pending_q == PEND_MAX) begin
                            drop_tick_d = 1'b1;
                        end else begin
                            pending_d = pending_q + PEND_W'(1);
                        end
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_out_d = (state_d == ST_ON);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            led_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= '0;
            drop_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_out_q   <= led_out_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            drop_tick_q <= drop_tick_d;
        end
    end

    assign led_out   = led_out_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign drop_tick = drop_tick_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch (queued build): directed scenarios plus random ticks,
// checked every cycle against a timeline model built from pulse start times.
module tb_pulse_stretch;

    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int PW   = 2;
    localparam int MAXP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick_in;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          drop_tick;

    int checks   = 0;
    int failures = 0;

    // Model: a pulse occupies [start, start+ON) lit, then OFF dark cycles.
    int cyc;
    bit m_active;
    int m_start;
    int m_pend;
    bit m_drop;

    int   led_hi;
    int   busy_hi;
    int   rises;
    logic led_prev;

    pulse_stretch #(
        .CNT_W      (4),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .PEND_W     (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .led_out   (led_out),
        .busy      (busy),
        .pending   (pending),
        .drop_tick (drop_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_start  = 0;
        m_pend   = 0;
        m_drop   = 1'b0;
        cyc      = 0;
        led_hi   = 0;
        busy_hi  = 0;
        rises    = 0;
        led_prev = 1'b0;
    endtask

    // Called at a negedge: check this cycle, drive the tick, advance the model.
    task automatic step(input bit t);
        int exp_led;
        int tot;
        exp_led = (m_active && (cyc - m_start) < ON) ? 1 : 0;
        chk("led_out",   {31'b0, led_out},   exp_led);
        chk("busy",      {31'b0, busy},      m_active ? 1 : 0);
        chk("pending",   {30'b0, pending},   m_pend);
        chk("drop_tick", {31'b0, drop_tick}, m_drop ? 1 : 0);
        if (led_out === 1'b1) led_hi++;
        if (busy === 1'b1) busy_hi++;
        if (led_out === 1'b1 && led_prev !== 1'b1) rises++;
        led_prev = led_out;

        tick_in = t;
        m_drop  = 1'b0;
        if (!m_active) begin
            if (t) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
            end
        end else if ((cyc - m_start) == ON + OFF - 1) begin
            tot = m_pend + (t ? 1 : 0);
            if (tot > 0) begin
                m_start = cyc + 1;
                m_pend  = tot - 1;
            end else begin
                m_active = 1'b0;
            end
        end else if (t) begin
            if (m_pend == MAXP) m_drop = 1'b1;
            else m_pend++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int ncyc, input logic [63:0] mask);
        for (int i = 0; i < ncyc; i++) step(mask[i]);
    endtask

    task automatic do_reset();
        tick_in = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tick_in = 1'b0;
        reset   = 1'b1;
        cyc     = 0;
        #12;
        chk("rst_led_out",   {31'b0, led_out},   0);
        chk("rst_busy",      {31'b0, busy},      0);
        chk("rst_pending",   {30'b0, pending},   0);
        chk("rst_drop_tick", {31'b0, drop_tick}, 0);

        // Single tick at cycle 10.
        do_reset();
        run(30, 64'b1 << 10);
        chk("s1_led_cycles",  led_hi,  4);
        chk("s1_busy_cycles", busy_hi, 6);
        chk("s1_pulses",      rises,   1);

        // Three ticks back to back: three pulses, queued.
        do_reset();
        run(40, (64'b1 << 10) | (64'b1 << 11) | (64'b1 << 12));
        chk("s2_led_cycles", led_hi, 12);
        chk("s2_pulses",     rises,  3);

        // Six consecutive ticks: queue saturates, four pulses total.
        do_reset();
        run(45, 64'b111111 << 10);
        chk("s3_pulses", rises, 4);

        // Asynchronous reset in the middle of a pulse with events queued.
        do_reset();
        run(13, (64'b1 << 10) | (64'b1 << 11) | (64'b1 << 12));
        #1 reset = 1'b1;
        #1;
        chk("s4_async_led_out", {31'b0, led_out}, 0);
        chk("s4_async_busy",    {31'b0, busy},    0);
        chk("s4_async_pending", {30'b0, pending}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(30, 64'b0);
        chk("s4_no_pulse_after", rises, 0);

        // Tick on the final gap cycle while the queue is full.
        do_reset();
        run(50, (64'b1111 << 10) | (64'b1 << 16));
        chk("s5_pulses", rises, 5);

        // Random traffic alternating sparse and bursty phases.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ((i / 100) % 2 == 0) step($urandom_range(0, 7) == 0);
            else step($urandom_range(0, 1) == 0);
        end
        for (int i = 0; i < 60; i++) step(1'b0);
        chk("rand_idle_end", {31'b0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
